dpram_arbiter: RTL and testbench
================================

Name: dpram_arbiter

Overview:
- Two-client controller for the dual-port RAM `dualport`: one write port, one read port, 1-cycle registered read.
- Sits between two requesters and the RAM. Per cycle it grants at most one write and at most one read, using an independent round-robin arbiter for each port.
- After reset it zero-fills the whole RAM, then routes each read response back to the client that issued it.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_valid  in  2  per-client request valid (bit i = client i).
- c_wr  in  2  per-client op: 1 = write, 0 = read.
- c_addr  in  2*ADDR_W  client i address in bits [i*ADDR_W +: ADDR_W].
- c_wdata  in  2*DATA_W  client i write data in bits [i*DATA_W +: DATA_W].
- c_ready  out  2  per-client grant; transfer occurs when c_valid[i] & c_ready[i].
- c_rvalid  out  2  per-client read response valid.
- c_rdata  out  DATA_W  read response data, shared by both clients and qualified by c_rvalid.
- init_done  out  1  high once the clear sweep is complete.
- enb  out  1  RAM enable.
- wr  out  1  RAM write strobe.
- rd  out  1  RAM read strobe.
- w_addr  out  ADDR_W  RAM write address.
- r_addr  out  ADDR_W  RAM read address.
- w_data  out  DATA_W  RAM write data.
- r_data  in  DATA_W  RAM read data, valid the cycle after rd.

Behaviour:
- Reset (rst=0, asynchronous), immediate effect:
  - state = INIT, init counter = 0, wr_ptr = rd_ptr = client 0, response tag cleared.
  - c_ready = 0, c_rvalid = 0, c_rdata = 0, init_done = 0.
  - enb = wr = rd = 0; w_addr = r_addr = w_data = 0.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle drives enb=1, wr=1, rd=0, w_addr = counter, w_data = 0; counter increments.
  - After the cycle that writes DEPTH-1, the next state is RUN. INIT lasts exactly DEPTH cycles after rst rises.
  - c_ready = 0 throughout INIT.
- RUN:
  - init_done = 1 and stays 1 until reset. RUN is never left except via reset.
  - Client rule: each client presents at most one request at a time and holds c_valid, c_wr, c_addr and c_wdata stable until it sees c_ready.
  - Write arbitration, among clients with c_valid & c_wr:
    - One requester: it is granted.
    - Both requesting: the client at wr_ptr is granted.
    - After any write grant, wr_ptr = the other client.
  - Read arbitration, among clients with c_valid & ~c_wr: same rule using rd_ptr.
  - Hazard: if the granted read address equals the granted write address in the same cycle, the read grant is withheld.
    - The write proceeds and rd_ptr is unchanged.
    - The read is granted next cycle and returns the new data.
  - A read and a write to different addresses are both granted in the same cycle.
- RAM drive and client grant, both combinational from the grants:
  - wr = write grant present; rd = read grant present; enb = wr | rd.
  - w_addr / w_data are muxed from the write winner; r_addr from the read winner.
  - Address and data outputs hold their previous value when that port is idle.
  - c_ready[i] = client i granted this cycle.
- Read response:
  - Winner id is registered at the read handshake.
  - The next cycle: c_rvalid[id] = 1 for exactly one cycle, c_rdata = r_data.
  - Back-to-back reads produce back-to-back responses. No ordering stall; throughput is 1 read + 1 write per cycle.
- Reset asserted mid-operation: any in-flight response is dropped (no c_rvalid) and the FSM returns to INIT, so the sweep repeats.
- Wrap-around: the init counter is ADDR_W+1 bits wide, so the terminal count is detectable; no address wraps in RUN because addresses come from the clients.

Test Plan:
- Release rst; hold c_valid=2'b11 -> c_ready=0 for 16 cycles; wr=1 with w_addr 0..15 and w_data=0; init_done rises on cycle 17, and c_ready goes high that cycle.
- After init, client 0 writes addr 3 = 8'hA5, then client 0 reads addr 3 -> c_rvalid[0] one cycle after the read handshake, c_rdata=8'hA5; c_rvalid[1] stays 0.
- Both clients hold write requests (addr 1 = 8'h11, addr 2 = 8'h22) -> grants client 0 then client 1 in successive cycles; a second round starts again at client 0; RAM holds 8'h11 and 8'h22.
- Same cycle, client 0 writes addr 5 = 8'h3C and client 1 reads addr 5 -> write granted, read stalled 1 cycle, then granted; c_rvalid[1] with c_rdata=8'h3C.
- Same cycle, client 0 writes addr 6 and client 1 reads addr 7 (pre-written 8'h77) -> both c_ready high together; c_rvalid[1] next cycle with 8'h77.
- Reset pulsed the cycle after a read handshake -> no c_rvalid; init_done=0; a fresh 16-cycle sweep runs; a read of addr 3 afterwards returns 8'h00.

Source files
------------

// File: rtl/dpram_arbiter.sv
// Two-client front end for a dual-port RAM: zero-fills the RAM after reset, then
// round-robin arbitrates one write and one read per cycle and routes read responses.
module dpram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          c_valid,
  input  logic [1:0]          c_wr,
  input  logic [2*ADDR_W-1:0] c_addr,
  input  logic [2*DATA_W-1:0] c_wdata,
  output logic [1:0]          c_ready,
  output logic [1:0]          c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  output logic                init_done,
  output logic                enb,
  output logic                wr,
  output logic                rd,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W-1:0]   r_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(Depth - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic                wr_ptr_q, rd_ptr_q;
  logic                rvalid_q, rtag_q;
  logic [ADDR_W-1:0]   w_addr_q, r_addr_q;
  logic [DATA_W-1:0]   w_data_q;

  logic [1:0]          wreq, rreq;
  logic                run, w_any, r_any_raw, r_any, hazard, w_sel, r_sel;
  logic [ADDR_W-1:0]   w_sel_addr, r_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

  always_comb begin
    run        = (state_q == StRun);
    wreq       = c_valid & c_wr;
    rreq       = c_valid & ~c_wr;
    w_any      = run & (|wreq);
    r_any_raw  = run & (|rreq);
    w_sel      = (&wreq) ? wr_ptr_q : wreq[1];
    r_sel      = (&rreq) ? rd_ptr_q : rreq[1];
    w_sel_addr = w_sel ? c_addr[2*ADDR_W-1:ADDR_W] : c_addr[ADDR_W-1:0];
    r_sel_addr = r_sel ? c_addr[2*ADDR_W-1:ADDR_W] : c_addr[ADDR_W-1:0];
    w_sel_data = w_sel ? c_wdata[2*DATA_W-1:DATA_W] : c_wdata[DATA_W-1:0];
    // Same-address read waits a cycle so it observes the newly written data.
    hazard     = w_any & r_any_raw & (r_sel_addr == w_sel_addr);
    r_any      = r_any_raw & ~hazard;
    c_ready    = ({w_sel, ~w_sel} & {2{w_any}}) | ({r_sel, ~r_sel} & {2{r_any}});
  end

  always_comb begin
    enb    = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    w_addr = w_addr_q;
    w_data = w_data_q;
    r_addr = r_addr_q;
    if (state_q == StInit) begin
      // Gated by rst so the RAM stays idle while reset is held.
      enb    = rst;
      wr     = rst;
      w_addr = cnt_q[ADDR_W-1:0];
      w_data = '0;
    end else begin
      wr  = w_any;
      rd  = r_any;
      enb = w_any | r_any;
      if (w_any) begin
        w_addr = w_sel_addr;
        w_data = w_sel_data;
      end
      if (r_any) begin
        r_addr = r_sel_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rvalid_q <= 1'b0;
      rtag_q   <= 1'b0;
      w_addr_q <= '0;
      r_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_addr_q <= w_addr;
      r_addr_q <= r_addr;
      w_data_q <= w_data;
      rvalid_q <= r_any;
      if (r_any) begin
        rtag_q   <= r_sel;
        rd_ptr_q <= ~r_sel;
      end
      if (w_any) begin
        wr_ptr_q <= ~w_sel;
      end
      if (state_q == StInit) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_q <= StRun;
        end
      end
    end
  end

  assign init_done = run;
  assign c_rvalid  = rvalid_q ? (rtag_q ? 2'b10 : 2'b01) : 2'b00;
  assign c_rdata   = rvalid_q ? r_data : '0;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM attached.
module tb_dpram_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          c_valid, c_wr;
  logic [2*ADDR_W-1:0] c_addr;
  logic [2*DATA_W-1:0] c_wdata;
  logic [1:0]          c_ready, c_rvalid;
  logic [DATA_W-1:0]   c_rdata;
  logic                init_done, enb, wr, rd;
  logic [ADDR_W-1:0]   w_addr, r_addr;
  logic [DATA_W-1:0]   w_data, r_data;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  int ntests = 0;
  int nfail  = 0;

  dpram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_valid   (c_valid),
    .c_wr      (c_wr),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_ready   (c_ready),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .init_done (init_done),
    .enb       (enb),
    .wr        (wr),
    .rd        (rd),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .w_data    (w_data),
    .r_data    (r_data)
  );

  always #5 clk = ~clk;

  // RAM model: write port and 1-cycle registered read port.
  always @(posedge clk) begin
    if (enb && wr) mem[w_addr] <= w_data;
    if (enb && rd) r_data <= mem[r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    c_valid = v;
    c_wr    = w;
    c_addr  = {a1, a0};
    c_wdata = {d1, d0};
  endtask

  // Called right after rst rises on a falling edge; returns on the 17th falling edge.
  task automatic sweep_check();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_ready", c_ready, 2'b00);
      chk("init_wr", wr, 1'b1);
      chk("init_enb", enb, 1'b1);
      chk("init_rd", rd, 1'b0);
      chk("init_waddr", w_addr, i);
      chk("init_wdata", w_data, 8'h00);
      chk("init_done_lo", init_done, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    drive(2'b11, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #2;
    chk("rst_ready", c_ready, 2'b00);
    chk("rst_rvalid", c_rvalid, 2'b00);
    chk("rst_rdata", c_rdata, 8'h00);
    chk("rst_done", init_done, 1'b0);
    chk("rst_enb", enb, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_waddr", w_addr, 4'd0);

    @(negedge clk);
    rst = 1'b1;
    sweep_check();

    // First RUN cycle: both clients read addr 0, round robin starts at client 0.
    #1;
    chk("run_done", init_done, 1'b1);
    chk("run_ready0", c_ready, 2'b01);
    chk("run_rd", rd, 1'b1);
    chk("run_raddr", r_addr, 4'd0);
    @(negedge clk);
    drive(2'b10, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("rr_rvalid0", c_rvalid, 2'b01);
    chk("rr_rdata0", c_rdata, 8'h00);
    chk("rr_ready1", c_ready, 2'b10);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("rr_rvalid1", c_rvalid, 2'b10);
    chk("rr_rdata1", c_rdata, 8'h00);
    chk("idle_enb", enb, 1'b0);

    // Client 0 writes addr 3 = A5 then reads it back.
    @(negedge clk);
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    #1;
    chk("w3_ready", c_ready, 2'b01);
    chk("w3_waddr", w_addr, 4'd3);
    chk("w3_wdata", w_data, 8'hA5);
    @(negedge clk);
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    #1;
    chk("r3_ready", c_ready, 2'b01);
    chk("r3_raddr", r_addr, 4'd3);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("r3_rvalid", c_rvalid, 2'b01);
    chk("r3_rdata", c_rdata, 8'hA5);
    chk("hold_waddr", w_addr, 4'd3);
    chk("hold_wdata", w_data, 8'hA5);

    // Client 1 pre-writes addr 7 = 77; write pointer then points at client 0.
    @(negedge clk);
    drive(2'b10, 2'b10, 4'd0, 4'd7, 8'h00, 8'h77);
    #1;
    chk("w7_ready", c_ready, 2'b10);

    // Two rounds of contending writes: 0, 1, 0, 1.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      drive(2'b11, 2'b11, 4'd1, 4'd2, 8'h11, 8'h22);
      #1;
      chk("ww_ready0", c_ready, 2'b01);
      chk("ww_waddr0", w_addr, 4'd1);
      chk("ww_wdata0", w_data, 8'h11);
      @(negedge clk);
      #1;
      chk("ww_ready1", c_ready, 2'b10);
      chk("ww_waddr1", w_addr, 4'd2);
      chk("ww_wdata1", w_data, 8'h22);
    end

    // Read back addrs 1 and 2; read pointer is at client 1.
    @(negedge clk);
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    #1;
    chk("rb_ready1", c_ready, 2'b10);
    @(negedge clk);
    drive(2'b01, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    #1;
    chk("rb_ready0", c_ready, 2'b01);
    chk("rb_rvalid1", c_rvalid, 2'b10);
    chk("rb_rdata2", c_rdata, 8'h22);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("rb_rvalid0", c_rvalid, 2'b01);
    chk("rb_rdata1", c_rdata, 8'h11);

    // Hazard: write and read of addr 5 in the same cycle.
    @(negedge clk);
    drive(2'b11, 2'b01, 4'd5, 4'd5, 8'h3C, 8'h00);
    #1;
    chk("hz_ready", c_ready, 2'b01);
    chk("hz_wr", wr, 1'b1);
    chk("hz_rd", rd, 1'b0);
    @(negedge clk);
    drive(2'b10, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00);
    #1;
    chk("hz_ready_rd", c_ready, 2'b10);
    chk("hz_raddr", r_addr, 4'd5);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("hz_rvalid", c_rvalid, 2'b10);
    chk("hz_rdata", c_rdata, 8'h3C);

    // Write addr 6 and read addr 7 in parallel.
    @(negedge clk);
    drive(2'b11, 2'b01, 4'd6, 4'd7, 8'h66, 8'h00);
    #1;
    chk("par_ready", c_ready, 2'b11);
    chk("par_enb", enb, 1'b1);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("par_rvalid", c_rvalid, 2'b10);
    chk("par_rdata", c_rdata, 8'h77);

    // Reset right after a read handshake drops the response and reruns the sweep.
    @(negedge clk);
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    #1;
    chk("pre_rst_ready", c_ready, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("mid_rst_rvalid", c_rvalid, 2'b00);
    chk("mid_rst_done", init_done, 1'b0);
    chk("mid_rst_enb", enb, 1'b0);
    chk("mid_rst_rdata", c_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    sweep_check();
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    #1;
    chk("post_done", init_done, 1'b1);
    chk("post_ready", c_ready, 2'b01);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    chk("post_rvalid", c_rvalid, 2'b01);
    chk("post_rdata", c_rdata, 8'h00);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
